// File: rtl/timer_cfg_loader.sv
// Byte-stream command loader for a timer's max/pwm/stop registers and its start/run handshake.
// Define TIMER_CFG_CHECKSUM_EN to require a fourth, XOR checksum byte per write frame.
module timer_cfg_loader #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_valid,
  output logic        o_byte_ready,
  output logic        o_we,
  output logic [1:0]  o_addr,
  output logic [15:0] o_wdata,
  output logic        o_start,
  input  logic        i_timer_end,
  output logic        o_busy,
  output logic        o_err,
  output logic [1:0]  o_err_code
);

  // state   | meaning
  // IDLE    | waiting for a command byte (write or start)
  // DATA_HI | expecting write data [15:8]
  // DATA_LO | expecting write data [7:0]
  // CHK     | expecting XOR checksum of the three frame bytes
  // WRITE   | one-cycle register write strobe to the timer
  // RUN     | timer running, waiting for i_timer_end
  typedef enum logic [2:0] {
    S_IDLE, S_DATA_HI, S_DATA_LO, S_CHK, S_WRITE, S_RUN
  } state_t;

  localparam logic [15:0] TO_LOAD   = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  CMD_START = 8'h80;
  localparam logic [7:0]  CMD_MAX   = 8'h02;

  state_t      state, state_nxt;
  logic        accept, in_frame, nxt_in_frame, timeout;
  logic [15:0] to_cnt;
  logic [1:0]  addr_q;
  logic [7:0]  hi_q;
  logic        start_q, err_q, err_nxt;
  logic [1:0]  code_q, code_nxt;
`ifdef TIMER_CFG_CHECKSUM_EN
  logic [7:0]  lo_q;
  logic [7:0]  chk_exp;
  assign chk_exp = {6'd0, addr_q} ^ hi_q ^ lo_q;
`endif

  assign accept       = i_byte_valid & o_byte_ready;
  assign in_frame     = state inside {S_DATA_HI, S_DATA_LO, S_CHK};
  assign nxt_in_frame = state_nxt inside {S_DATA_HI, S_DATA_LO, S_CHK};
  // Down-counter reloads on every accepted byte; zero with no byte means the gap hit TIMEOUT_CYCLES.
  assign timeout      = in_frame & ~accept & (to_cnt == 16'd0);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    code_nxt  = 2'd0;
    if (timeout) begin
      state_nxt = S_IDLE;
      err_nxt   = 1'b1;
      code_nxt  = 2'd2;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (i_byte == CMD_START)    state_nxt = S_RUN;
            else if (i_byte <= CMD_MAX) state_nxt = S_DATA_HI;
            else begin
              err_nxt  = 1'b1;
              code_nxt = 2'd1;
            end
          end
        end
        S_DATA_HI: if (accept) state_nxt = S_DATA_LO;
        S_DATA_LO: begin
          if (accept) begin
`ifdef TIMER_CFG_CHECKSUM_EN
            state_nxt = S_CHK;
`else
            state_nxt = S_WRITE;
`endif
          end
        end
        S_CHK: begin
`ifdef TIMER_CFG_CHECKSUM_EN
          if (accept) begin
            if (i_byte == chk_exp) state_nxt = S_WRITE;
            else begin
              state_nxt = S_IDLE;
              err_nxt   = 1'b1;
              code_nxt  = 2'd3;
            end
          end
`else
          state_nxt = S_IDLE;
`endif
        end
        S_WRITE: state_nxt = S_IDLE;
        S_RUN:   if (i_timer_end) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_byte_ready = state inside {S_IDLE, S_DATA_HI, S_DATA_LO, S_CHK};
    o_we         = (state == S_WRITE);
    o_busy       = (state == S_RUN);
    o_start      = start_q;
    o_err        = err_q;
    o_err_code   = code_q;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      to_cnt  <= 16'd0;
      addr_q  <= 2'd0;
      hi_q    <= 8'd0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'd0;
      o_addr  <= 2'd0;
      o_wdata <= 16'd0;
`ifdef TIMER_CFG_CHECKSUM_EN
      lo_q    <= 8'd0;
`endif
    end else begin
      start_q <= (state == S_IDLE) && (state_nxt == S_RUN);
      err_q   <= err_nxt;
      if (err_nxt) code_q <= code_nxt;

      if (!nxt_in_frame)        to_cnt <= 16'd0;
      else if (accept)          to_cnt <= TO_LOAD;
      else if (to_cnt != 16'd0) to_cnt <= to_cnt - 16'd1;

      if (state == S_IDLE && accept)    addr_q <= i_byte[1:0];
      if (state == S_DATA_HI && accept) hi_q   <= i_byte;
`ifdef TIMER_CFG_CHECKSUM_EN
      if (state == S_DATA_LO && accept) lo_q   <= i_byte;
`endif

      // Output registers only change on a committed frame, so they hold the last write otherwise.
      if (state_nxt == S_WRITE) begin
        o_addr <= addr_q;
`ifdef TIMER_CFG_CHECKSUM_EN
        o_wdata <= {hi_q, lo_q};
`else
        o_wdata <= {hi_q, i_byte};
`endif
      end
    end
  end

endmodule
